// File: rtl/trace_buffer.sv
// Retire-trace capture buffer: circular PC/instruction log frozen by a PC-match trigger, drained oldest-first.
// Optional register-write capture fields are enabled with the TRACE_REGWR_EN macro.
module trace_buffer #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic [AW:0]        post_count,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               retire,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
`ifdef TRACE_REGWR_EN
  input  logic               reg_we,
  input  logic [4:0]         reg_da,
  input  logic [63:0]        reg_data,
  output logic               rd_we,
  output logic [4:0]         rd_da,
  output logic [63:0]        rd_data,
`endif
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [AW:0]        fill,
  output logic               wrapped,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            st;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     remaining;
  logic [AW:0]       fill_q;
  logic              wrapped_q;
  logic              capturing;
  logic              wr_en;
  logic              pop;
  logic              full;
  logic [AW-1:0]     post_clamped;

  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
`ifdef TRACE_REGWR_EN
  logic               mem_we    [DEPTH];
  logic [4:0]         mem_da    [DEPTH];
  logic [63:0]        mem_data  [DEPTH];
`endif

  assign capturing    = (st == ARMED) || (st == TRIGGERED);
  assign wr_en        = retire && capturing && !arm && !reset;
  assign full         = (fill_q == (AW+1)'(DEPTH));
  assign rd_valid     = (st == DONE) && (fill_q != '0);
  assign pop          = rd_valid && rd_ready;
  // fill==DEPTH has zero low bits, so the head lands back on wr_ptr as intended.
  assign rd_ptr       = wr_ptr - fill_q[AW-1:0];
  // Clamping keeps the trigger entry from being overwritten by post-trigger writes.
  assign post_clamped = (post_count > (AW+1)'(DEPTH-1)) ? AW'(DEPTH-1) : post_count[AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
      remaining <= '0;
    end else if (arm) begin
      st        <= ARMED;
      wr_ptr    <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
      remaining <= post_clamped;
    end else begin
      case (st)
        IDLE: ;
        ARMED, TRIGGERED: begin
          if (retire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full) wrapped_q <= 1'b1;
            else      fill_q    <= fill_q + 1'b1;
            if (st == ARMED) begin
              if (pc == trig_pc) st <= (remaining == '0) ? DONE : TRIGGERED;
            end else begin
              remaining <= remaining - 1'b1;
              if (remaining == AW'(1)) st <= DONE;
            end
          end
        end
        DONE: begin
          if (pop) fill_q <= fill_q - 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= instruction;
`ifdef TRACE_REGWR_EN
      mem_we[wr_ptr]    <= reg_we;
      mem_da[wr_ptr]    <= reg_da;
      mem_data[wr_ptr]  <= reg_data;
`endif
    end
  end

  assign rd_pc    = rd_valid ? mem_pc[rd_ptr]    : '0;
  assign rd_instr = rd_valid ? mem_instr[rd_ptr] : '0;
`ifdef TRACE_REGWR_EN
  assign rd_we    = rd_valid ? mem_we[rd_ptr]    : 1'b0;
  assign rd_da    = rd_valid ? mem_da[rd_ptr]    : '0;
  assign rd_data  = rd_valid ? mem_data[rd_ptr]  : '0;
`endif

  assign fill    = fill_q;
  assign wrapped = wrapped_q;
  assign state   = st;

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: directed retire streams, queued expected readout checked by a monitor.
module tb_trace_buffer;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               arm;
  logic [AW:0]        post_count;
  logic [PC_W-1:0]    trig_pc;
  logic               retire;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instruction;
  logic               rd_ready;
  logic               rd_valid;
  logic [PC_W-1:0]    rd_pc;
  logic [INSTR_W-1:0] rd_instr;
  logic [AW:0]        fill;
  logic               wrapped;
  logic [1:0]         state;
`ifdef TRACE_REGWR_EN
  logic               reg_we;
  logic [4:0]         reg_da;
  logic [63:0]        reg_data;
  logic               rd_we;
  logic [4:0]         rd_da;
  logic [63:0]        rd_data;
`endif

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  trace_buffer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .arm(arm), .post_count(post_count),
    .trig_pc(trig_pc), .retire(retire), .pc(pc), .instruction(instruction),
`ifdef TRACE_REGWR_EN
    .reg_we(reg_we), .reg_da(reg_da), .reg_data(reg_data),
    .rd_we(rd_we), .rd_da(rd_da), .rd_data(rd_data),
`endif
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .fill(fill), .wrapped(wrapped), .state(state)
  );

  always #5 clock = ~clock;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm(input logic [AW:0] pcount, input logic [PC_W-1:0] tpc);
    arm = 1'b1; post_count = pcount; trig_pc = tpc;
    step();
    arm = 1'b0;
  endtask

  task automatic do_retire(input logic [PC_W-1:0] p);
    retire = 1'b1; pc = p; instruction = instr_of(p);
    step();
    retire = 1'b0;
  endtask

  task automatic expect_entry(input logic [PC_W-1:0] p);
    entry_t e;
    e.pc = p; e.instr = instr_of(p);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    rd_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    rd_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain_timeout: left %0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check({name, "_empty_valid"}, 64'(rd_valid), 64'd0);
    check({name, "_empty_pc"}, rd_pc, 64'd0);
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clock) begin
    if (rd_valid && rd_ready) begin
      entry_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: got pc 0x%0h expected no entry", rd_pc);
      end else begin
        e = exp_q.pop_front();
        if (rd_pc !== e.pc || rd_instr !== e.instr) begin
          failures++;
          $display("FAIL pop_data: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                   rd_pc, rd_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; arm = 1'b0; post_count = '0; trig_pc = '0;
    retire = 1'b1; pc = 64'h44; instruction = instr_of(64'h44); rd_ready = 1'b0;
`ifdef TRACE_REGWR_EN
    reg_we = 1'b0; reg_da = '0; reg_data = '0;
`endif
    step(); step();
    check("rst_state", 64'(state), 64'd0);
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_wrapped", 64'(wrapped), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_pc", rd_pc, 64'd0);
    reset = 1'b0; retire = 1'b0;
    step();

    // Basic trigger at 0x20 with three post-trigger entries
    do_arm(5'd3, 64'h20);
    check("basic_armed", 64'(state), 64'd1);
    for (int i = 0; i < 12; i++) begin
      do_retire(64'(i * 4));
      if (i == 7)  check("basic_pre_trig", 64'(state), 64'd1);
      if (i == 8)  check("basic_trig", 64'(state), 64'd2);
      if (i == 10) check("basic_post", 64'(state), 64'd2);
      if (i == 11) check("basic_done", 64'(state), 64'd3);
    end
    check("basic_fill", 64'(fill), 64'd12);
    check("basic_wrapped", 64'(wrapped), 64'd0);
    do_retire(64'h30);
    check("basic_frozen_fill", 64'(fill), 64'd12);
    check("basic_head", rd_pc, 64'h0);
    for (int i = 0; i < 12; i++) expect_entry(64'(i * 4));
    drain("basic");
    check("basic_stay_done", 64'(state), 64'd3);

    // Wrap: 69 retires into 16 entries
    do_arm(5'd4, 64'h100);
    for (int i = 0; i <= 68; i++) do_retire(64'(i * 4));
    check("wrap_state", 64'(state), 64'd3);
    check("wrap_fill", 64'(fill), 64'd16);
    check("wrap_wrapped", 64'(wrapped), 64'd1);
    check("wrap_head", rd_pc, 64'hD4);
    for (int i = 53; i <= 68; i++) expect_entry(64'(i * 4));
    drain("wrap");

    // Zero post-trigger
    do_arm(5'd0, 64'h08);
    check("zero_rearm_wrapped", 64'(wrapped), 64'd0);
    do_retire(64'h00);
    do_retire(64'h04);
    do_retire(64'h08);
    check("zero_done", 64'(state), 64'd3);
    do_retire(64'h0C);
    check("zero_fill", 64'(fill), 64'd3);
    expect_entry(64'h00); expect_entry(64'h04); expect_entry(64'h08);
    drain("zero");

    // Clamp: post_count 31 behaves as 15, trigger entry survives
    do_arm(5'd31, 64'h00);
    for (int i = 0; i < 16; i++) begin
      do_retire(64'(i * 4));
      if (i == 14) check("clamp_trig", 64'(state), 64'd2);
      if (i == 15) check("clamp_done", 64'(state), 64'd3);
    end
    check("clamp_fill", 64'(fill), 64'd16);
    check("clamp_wrapped", 64'(wrapped), 64'd0);
    for (int i = 0; i < 16; i++) expect_entry(64'(i * 4));
    drain("clamp");

    // Read handshake: stall, toggled pops, re-arm, reset mid-drain
    do_arm(5'd4, 64'h00);
    for (int i = 0; i < 5; i++) do_retire(64'(i * 4));
    check("hs_done", 64'(state), 64'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hs_stall_valid", 64'(rd_valid), 64'd1);
      check("hs_stall_head", rd_pc, 64'h00);
      check("hs_stall_fill", 64'(fill), 64'd5);
    end
    expect_entry(64'h00); expect_entry(64'h04);
    rd_ready = 1'b1; step();
    rd_ready = 1'b0; step();
    rd_ready = 1'b1; step();
    rd_ready = 1'b0;
    check("hs_toggle_fill", 64'(fill), 64'd3);
    check("hs_toggle_head", rd_pc, 64'h08);
    check("hs_toggle_consumed", 64'(exp_q.size()), 64'd0);
    do_arm(5'd0, 64'h00);
    check("hs_rearm_fill", 64'(fill), 64'd0);
    check("hs_rearm_state", 64'(state), 64'd1);
    check("hs_rearm_valid", 64'(rd_valid), 64'd0);
    do_retire(64'h40);
    do_retire(64'h44);
    do_retire(64'h00);
    check("hs_refill", 64'(fill), 64'd3);
    expect_entry(64'h40);
    rd_ready = 1'b1; step();
    rd_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("hs_reset_state", 64'(state), 64'd0);
    check("hs_reset_valid", 64'(rd_valid), 64'd0);
    check("hs_reset_fill", 64'(fill), 64'd0);
    check("hs_reset_consumed", 64'(exp_q.size()), 64'd0);
    do_retire(64'h48);
    check("idle_ignores_retire", 64'(fill), 64'd0);

`ifdef TRACE_REGWR_EN
    do_arm(5'd0, 64'h10);
    reg_we = 1'b1; reg_da = 5'd5; reg_data = 64'hDEAD;
    do_retire(64'h10);
    reg_we = 1'b0; reg_da = '0; reg_data = '0;
    check("regwr_done", 64'(state), 64'd3);
    check("regwr_we", 64'(rd_we), 64'd1);
    check("regwr_da", 64'(rd_da), 64'd5);
    check("regwr_data", rd_data, 64'hDEAD);
    expect_entry(64'h10);
    drain("regwr");
    check("regwr_cleared_data", rd_data, 64'd0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Synthesizable retire-trace capture buffer for the single-cycle Processor. It records one entry per retired instruction (PC plus instruction word) in a circular buffer. A PC-match trigger freezes the buffer after a programmable number of post-trigger entries. The frozen trace is then drained oldest-first over a valid/ready port. It sits beside `Processor`, tapping the PC and instruction wires, and gives benches and on-board debug the same visibility that hierarchical probes give in simulation.

## Interface
Parameters:
- `PC_W`, 64, PC width
- `INSTR_W`, 32, instruction width
- `DEPTH`, 16, entry count; power of two, ≥2; `AW = $clog2(DEPTH)` is derived

Ports:
- `clock`  in  1  rising-edge clock, the only clock
- `reset`  in  1  synchronous, active-high
- `arm`  in  1  one-cycle pulse: clear the buffer and start capture
- `post_count`  in  AW+1  post-trigger entries, latched on `arm`; clamped to DEPTH-1
- `trig_pc`  in  PC_W  trigger PC, compared live
- `retire`  in  1  an instruction retires this cycle
- `pc`  in  PC_W  PC of the retiring instruction
- `instruction`  in  INSTR_W  retiring instruction word
- `rd_ready`  in  1  consumer accepts the head entry
- `rd_valid`  out  1  head entry is available
- `rd_pc`  out  PC_W  head entry PC
- `rd_instr`  out  INSTR_W  head entry instruction
- `fill`  out  AW+1  number of held entries, 0..DEPTH
- `wrapped`  out  1  at least one entry was overwritten since `arm`
- `state`  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE

## Operation
- **IDLE:** no capture. `arm` moves to ARMED.
- **On `arm` (any state):**
  - `wr_ptr`, `fill` and `wrapped` are cleared.
  - `post_count` is latched into `remaining`, clamped to DEPTH-1.
  - The next state is ARMED.
  - A `retire` in the same cycle is dropped; `arm` has priority over everything except `reset`.
- **ARMED, each `retire`:**
  - The entry is written at `wr_ptr`, and `wr_ptr` increments mod DEPTH.
  - `fill` increments, saturating at DEPTH.
  - Writing while `fill==DEPTH` overwrites the oldest entry and sets `wrapped`.
- **Trigger (ARMED only):** `retire && pc==trig_pc`.
  - The trigger entry is written first.
  - If `remaining==0`, go to DONE; otherwise go to TRIGGERED.
  - PC matches in the other states are ignored.
- **TRIGGERED, each `retire`:**
  - The entry is written with the same wrap rules as ARMED, and `remaining` decrements.
  - The write that takes `remaining` to 0 moves the block to DONE.
- **DONE:**
  - Capture is frozen; `retire` is ignored.
  - `rd_valid = (fill!=0)`.
  - The head entry is at `rd_ptr = (wr_ptr - fill) mod DEPTH`.
  - A pop (`rd_valid && rd_ready`) decrements `fill`; `wr_ptr` is unchanged.
  - The block stays in DONE after draining until `arm` or `reset`.
- **Outside DONE:** `rd_valid=0` and `rd_ready` is ignored.
- **Clamp:** the clamp to DEPTH-1 guarantees that the trigger entry always survives.

## Timing
- All state, pointers and the array are registered on the rising edge of `clock`.
- **Reset values:**
  - `state=0`, `fill=0`, `wrapped=0`, `rd_valid=0`, `rd_pc=0`, `rd_instr=0`.
  - Array contents are don't-care.
  - `rd_*` data outputs are forced to 0 whenever `rd_valid=0`.
- **`reset` mid-operation** (any state, including mid-drain) returns to IDLE at the next edge and discards the contents.
- **Write latency:** a retire in cycle N is counted in `fill` in cycle N+1.
- **Trigger latency:** the new `state` is visible in cycle N+1.
- **Read path:** combinational from the array at `rd_ptr`. The head is valid in the same cycle as `rd_valid`.
- **Pop timing:** after a pop at edge N, the next entry is presented in cycle N+1. Throughput is one entry per cycle.
- **Handshake:** `rd_valid` and the head data hold stable while `rd_ready=0`.

## Configuration
- Macro: `TRACE_REGWR_EN`.
- **Defined:** the block adds register-write capture.
  - Inputs: `reg_we` (1), `reg_da` (5), `reg_data` (64).
  - Outputs: `rd_we`, `rd_da`, `rd_data`.
  - These fields are stored per entry alongside the PC and instruction, using identical pointer, wrap and clear behaviour.
- **Undefined:** the ports and storage are absent, and behaviour is otherwise identical.

## Test plan
All scenarios use DEPTH=16.

- **Reset:** assert `reset` 2 cycles with `retire=1` → `state=0`, `fill=0`, `wrapped=0`, `rd_valid=0`, `rd_pc=0`.
- **Basic trigger and drain:**
  - Stimulus: `arm` with `post_count=3` and `trig_pc=0x20`; retire PC 0x00,0x04,…, one per cycle.
  - State: 2 the cycle after PC 0x20 retires; 3 after PC 0x2C.
  - Buffer: `fill=12`, `wrapped=0`.
  - Drain with `rd_ready=1`: 0x00..0x2C in order, then `rd_valid=0`.
- **Wrap:**
  - Stimulus: `post_count=4`, `trig_pc=0x100`; retire 0x000..0x110 step 4 (69 retires).
  - Result: `fill=16`, `wrapped=1`; readout is 0xD4..0x110, 16 entries.
- **Zero post-trigger:** `post_count=0`, `trig_pc=0x08` → `state=3` the cycle after PC 0x08 retires; the last entry read is 0x08.
- **Read handshake:**
  - Stimulus: in DONE with `fill=5`, hold `rd_ready=0` for 4 cycles.
  - Stall: head is stable and `fill=5`.
  - Toggled pops: 1/0/1 → `fill=3`.
  - Re-arm: `arm` → `fill=0`, `state=1`.
  - Reset mid-drain: `state=0`, `rd_valid=0`.
- **`TRACE_REGWR_EN` defined:**
  - Stimulus: retire PC 0x10 with `reg_we=1`, `reg_da=5`, `reg_data=0xDEAD` as the trigger entry, `post_count=0`.
  - Result: the drained entry shows `rd_we=1`, `rd_da=5`, `rd_data=0xDEAD`.
